// File: rtl/response_pkg.sv
`default_nettype none
// ============================================================================
// Module   : response_pkg
// Purpose  : Shared types and constants for the host response path.
//            - FSM state encoding used by response_unit.
//            - Packet kind encoding and fixed packet bytes.
//            - Helper that builds the header byte of a packet.
// Revision : 1.0 - initial release
// ============================================================================
package response_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SYNC     = 3'd1,
      ST_HEAD     = 3'd2,
      ST_PAYLOAD  = 3'd3,
      ST_CHECKSUM = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      KIND_ACK  = 2'd0,
      KIND_NAK  = 2'd1,
      KIND_DATA = 2'd2
   } kind_t;

   localparam logic [7:0] SYNC_BYTE   = 8'h00;
   localparam logic [3:0] ACK_PREFIX  = 4'hA;
   localparam logic [7:0] NAK_BYTE    = 8'hEE;
   localparam logic [3:0] DATA_PREFIX = 4'hD;

   // Second byte of every packet: identifies the packet and carries either
   // the command code (ACK) or the payload length (DATA).
   function automatic logic [7:0] head_byte(input kind_t kind,
                                            input logic [3:0] code,
                                            input logic [3:0] n_bytes);
      logic [7:0] b;
      case (kind)
         KIND_ACK:  b = {ACK_PREFIX, code};
         KIND_DATA: b = {DATA_PREFIX, n_bytes};
         default:   b = NAK_BYTE;
      endcase
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_byte
// Purpose  : 8N1 byte serializer. One start bit (0), eight data bits LSB
//            first, one stop bit (1), each held BIT_CYCLES clocks.
//            A new byte may be started in the last cycle of the current stop
//            bit so consecutive bytes go out back-to-back.
// Ports    : i_clock      - clock, rising edge
//            i_reset_n    - asynchronous active-low reset
//            i_start      - load i_data and begin a frame (honoured when o_ready)
//            i_data[7:0]  - byte to send
//            o_tx         - serial line, idles high
//            o_ready      - serializer can accept i_start this cycle
//            o_done_byte  - last cycle of the stop bit
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_byte #(
   parameter int BIT_CYCLES = 16
) (
   input  logic       i_clock,
   input  logic       i_reset_n,
   input  logic       i_start,
   input  logic [7:0] i_data,
   output logic       o_tx,
   output logic       o_ready,
   output logic       o_done_byte
);

   localparam int              CNT_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_CYCLES - 1);

   logic             active_q,   active_d;
   logic [9:0]       frame_q,    frame_d;
   logic [3:0]       bit_cnt_q,  bit_cnt_d;
   logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
   logic             w_bit_end;
   logic             w_frame_end;

   always_comb begin
      w_bit_end   = active_q && (baud_cnt_q == BAUD_LAST);
      w_frame_end = w_bit_end && (bit_cnt_q == 4'd9);
      active_d    = active_q;
      frame_d     = frame_q;
      bit_cnt_d   = bit_cnt_q;
      baud_cnt_d  = baud_cnt_q;

      if (i_start && (!active_q || w_frame_end)) begin
         // Whole frame is loaded at once; bit 0 is the start bit.
         active_d   = 1'b1;
         frame_d    = {1'b1, i_data, 1'b0};
         bit_cnt_d  = 4'd0;
         baud_cnt_d = '0;
      end else if (w_frame_end) begin
         active_d   = 1'b0;
         bit_cnt_d  = 4'd0;
         baud_cnt_d = '0;
      end else if (w_bit_end) begin
         frame_d    = {1'b1, frame_q[9:1]};
         bit_cnt_d  = bit_cnt_q + 4'd1;
         baud_cnt_d = '0;
      end else if (active_q) begin
         baud_cnt_d = baud_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         active_q   <= 1'b0;
         frame_q    <= '1;
         bit_cnt_q  <= 4'd0;
         baud_cnt_q <= '0;
      end else begin
         active_q   <= active_d;
         frame_q    <= frame_d;
         bit_cnt_q  <= bit_cnt_d;
         baud_cnt_q <= baud_cnt_d;
      end
   end

   assign o_tx        = active_q ? frame_q[0] : 1'b1;
   assign o_ready     = !active_q || w_frame_end;
   assign o_done_byte = w_frame_end;

endmodule
`default_nettype wire

// File: rtl/response_unit.sv
`default_nettype none
// ============================================================================
// Module   : response_unit
// Purpose  : Builds framed response packets (ACK / NAK / DATA) from command
//            outcome pulses and sample-ready events and sends them on an
//            8N1 UART line. One request is handled at a time; anything that
//            arrives while a packet is in flight is dropped.
// Ports    : i_clock, i_reset_n      - clock / async active-low reset
//            i_succes, i_cmd_code    - command accepted pulse + opcode
//            i_error                 - command rejected pulse
//            i_sample_valid,i_sample - sample word ready to send (MSB first)
//            o_tx                    - serial line, idles high
//            o_busy                  - packet in progress
//            o_done                  - one-cycle pulse after last stop bit
//            o_drop                  - one-cycle pulse per discarded request
// Options  : RESPONSE_CHECKSUM_EN - append XOR of header+payload bytes
// Revision : 1.0 - initial release
// ============================================================================
module response_unit #(
   parameter int DATA_SIZE      = 8,
   parameter int CLK_FREQUENCY  = 100000000,
   parameter int UART_FREQUENCY = 9600,
   parameter int N_SAMPLE_BYTES = 4
) (
   input  logic                                i_clock,
   input  logic                                i_reset_n,
   input  logic                                i_succes,
   input  logic                                i_error,
   input  logic [3:0]                          i_cmd_code,
   input  logic                                i_sample_valid,
   input  logic [DATA_SIZE*N_SAMPLE_BYTES-1:0] i_sample,
   output logic                                o_tx,
   output logic                                o_busy,
   output logic                                o_done,
   output logic                                o_drop
);
   import response_pkg::*;

   localparam int         BIT_CYCLES = CLK_FREQUENCY / UART_FREQUENCY;
   localparam int         SAMPLE_W   = DATA_SIZE * N_SAMPLE_BYTES;
   localparam logic [3:0] N_NIBBLE   = 4'(N_SAMPLE_BYTES);
   localparam logic [3:0] LAST_IDX   = 4'(N_SAMPLE_BYTES - 1);

   generate
      if (N_SAMPLE_BYTES < 1 || N_SAMPLE_BYTES > 15) begin : g_bad_n_sample_bytes
         $error("response_unit: N_SAMPLE_BYTES must be in 1..15");
      end
   endgenerate

   state_t                state_q,      state_d;
   kind_t                 kind_q,       kind_d;
   logic [3:0]            code_q,       code_d;
   logic [SAMPLE_W-1:0]   sample_q,     sample_d;
   logic [3:0]            idx_q,        idx_d;
   logic [1:0]            launch_q,     launch_d;
   logic                  drop_pend_q,  drop_pend_d;
   logic                  drop_q;

   logic       tx_start;
   logic [7:0] tx_data;
   logic       w_tx_ready;
   logic       w_byte_done;
   logic       w_finish;
   logic [7:0] w_head;
   logic [3:0] w_pay_sel;
   logic [7:0] w_pay_byte;

   assign w_head = head_byte(kind_q, code_q, N_NIBBLE);

   // Payload byte about to be started: byte 0 when leaving HEAD, otherwise
   // the byte after the one currently on the line.
   always_comb begin
      w_pay_sel  = (state_q == ST_HEAD) ? 4'd0 : idx_q + 4'd1;
      w_pay_byte = 8'h00;
      for (int k = 0; k < N_SAMPLE_BYTES; k++) begin
         if (w_pay_sel == 4'(k)) w_pay_byte = sample_q[SAMPLE_W-DATA_SIZE*(k+1) +: 8];
      end
   end

`ifdef RESPONSE_CHECKSUM_EN
   logic [7:0] w_chk;
   always_comb begin
      w_chk = w_head;
      if (kind_q == KIND_DATA) begin
         for (int k = 0; k < N_SAMPLE_BYTES; k++) begin
            w_chk = w_chk ^ sample_q[SAMPLE_W-DATA_SIZE*(k+1) +: 8];
         end
      end
   end
`endif

   always_comb begin
      state_d     = state_q;
      kind_d      = kind_q;
      code_d      = code_q;
      sample_d    = sample_q;
      idx_d       = idx_q;
      launch_d    = launch_q;
      tx_start    = 1'b0;
      tx_data     = SYNC_BYTE;
      w_finish    = 1'b0;
      // Outside IDLE every request is discarded.
      drop_pend_d = (state_q != ST_IDLE) && (i_error || i_succes || i_sample_valid);

      case (state_q)
         ST_IDLE: begin
            if (i_error || i_succes || i_sample_valid) begin
               state_d  = ST_SYNC;
               idx_d    = 4'd0;
               launch_d = 2'd2;
               if (i_error) begin
                  kind_d = KIND_NAK;
               end else if (i_succes) begin
                  kind_d = KIND_ACK;
                  code_d = i_cmd_code;
               end else begin
                  kind_d   = KIND_DATA;
                  sample_d = i_sample;
               end
               // Losers of a simultaneous request are dropped.
               drop_pend_d = (i_error && (i_succes || i_sample_valid)) ||
                             (i_succes && i_sample_valid);
            end
         end
         ST_SYNC: begin
            // One idle cycle after capture before the sync byte starts.
            if (launch_q != 2'd0) begin
               launch_d = launch_q - 2'd1;
               if (launch_q == 2'd1) tx_start = 1'b1;
            end else if (w_byte_done) begin
               state_d  = ST_HEAD;
               tx_start = 1'b1;
               tx_data  = w_head;
            end
         end
         ST_HEAD: begin
            if (w_byte_done) begin
               if (kind_q == KIND_DATA) begin
                  state_d  = ST_PAYLOAD;
                  tx_start = 1'b1;
                  tx_data  = w_pay_byte;
               end else begin
                  w_finish = 1'b1;
               end
            end
         end
         ST_PAYLOAD: begin
            if (w_byte_done) begin
               if (idx_q == LAST_IDX) begin
                  w_finish = 1'b1;
               end else begin
                  idx_d    = idx_q + 4'd1;
                  tx_start = 1'b1;
                  tx_data  = w_pay_byte;
               end
            end
         end
         ST_CHECKSUM: begin
            if (w_byte_done) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (w_finish) begin
`ifdef RESPONSE_CHECKSUM_EN
         state_d  = ST_CHECKSUM;
         tx_start = 1'b1;
         tx_data  = w_chk;
`else
         state_d  = ST_DONE;
`endif
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= ST_IDLE;
         kind_q      <= KIND_NAK;
         code_q      <= 4'd0;
         sample_q    <= '0;
         idx_q       <= 4'd0;
         launch_q    <= 2'd0;
         drop_pend_q <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         kind_q      <= kind_d;
         code_q      <= code_d;
         sample_q    <= sample_d;
         idx_q       <= idx_d;
         launch_q    <= launch_d;
         drop_pend_q <= drop_pend_d;
         // Drop is reported one cycle after the decision edge.
         drop_q      <= drop_pend_q;
      end
   end

   uart_tx_byte #(
      .BIT_CYCLES (BIT_CYCLES)
   ) u_tx (
      .i_clock     (i_clock),
      .i_reset_n   (i_reset_n),
      .i_start     (tx_start),
      .i_data      (tx_data),
      .o_tx        (o_tx),
      .o_ready     (w_tx_ready),
      .o_done_byte (w_byte_done)
   );

   // Starts are only issued when the serializer is idle or finishing a stop bit.
   logic w_unused;
   assign w_unused = w_tx_ready;

   assign o_busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign o_done = (state_q == ST_DONE);
   assign o_drop = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_response_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_response_unit
// Purpose  : Self-checking bench for response_unit (BIT_CYCLES = 16,
//            N_SAMPLE_BYTES = 4). A UART receiver decodes o_tx; expected
//            packets come from a byte-list model of the packet formats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_response_unit;

   localparam int B      = 16;
   localparam int K_ACK  = 0;
   localparam int K_NAK  = 1;
   localparam int K_DATA = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_succes, i_error, i_sample_valid;
   logic [3:0]  i_cmd_code;
   logic [31:0] i_sample;
   logic        o_tx, o_busy, o_done, o_drop;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   int          first_fall = -1;
   logic [7:0]  rx_q[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  rx_b;

   typedef struct {
      logic        e, s, v;
      logic [3:0]  code;
      logic [31:0] samp;
      int          kind;
      logic        drop;
   } vec_t;
   vec_t tbl[12];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   response_unit #(
      .DATA_SIZE      (8),
      .CLK_FREQUENCY  (16),
      .UART_FREQUENCY (1),
      .N_SAMPLE_BYTES (4)
   ) dut (
      .i_clock        (clk),
      .i_reset_n      (rst_n),
      .i_succes       (i_succes),
      .i_error        (i_error),
      .i_cmd_code     (i_cmd_code),
      .i_sample_valid (i_sample_valid),
      .i_sample       (i_sample),
      .o_tx           (o_tx),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_drop         (o_drop)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Packet model: list of bytes the host should receive.
   function automatic void build_expected(input int kind, input logic [3:0] code,
                                          input logic [31:0] samp);
      logic [7:0] x;
      exp_q.delete();
      exp_q.push_back(8'h00);
      if (kind == K_ACK) exp_q.push_back({4'hA, code});
      else if (kind == K_NAK) exp_q.push_back(8'hEE);
      else begin
         exp_q.push_back(8'hD4);
         for (int k = 0; k < 4; k++) exp_q.push_back(samp[31-8*k -: 8]);
      end
`ifdef RESPONSE_CHECKSUM_EN
      x = 8'h00;
      for (int i = 1; i < exp_q.size(); i++) x = x ^ exp_q[i];
      exp_q.push_back(x);
`endif
      x = 8'h00;
   endfunction

   // UART receiver: samples each bit in its middle.
   always begin
      @(negedge clk);
      if (rst_n === 1'b1 && o_tx === 1'b0) begin
         if (first_fall < 0) first_fall = cyc;
         repeat (B/2) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (B) @(negedge clk);
            rx_b[i] = o_tx;
         end
         repeat (B) @(negedge clk);
         chk("stop bit", {31'd0, o_tx}, 32'd1);
         rx_q.push_back(rx_b);
      end
   end

   task automatic run_req(input vec_t t, input int collide_at, input string tag);
      int  e0;
      int  done_cyc;
      bit  got;
      build_expected(t.kind, t.code, t.samp);
      @(negedge clk);
      rx_q.delete();
      first_fall     = -1;
      i_error        = t.e;
      i_succes       = t.s;
      i_sample_valid = t.v;
      i_cmd_code     = t.code;
      i_sample       = t.samp;
      @(negedge clk);
      e0             = cyc;
      i_error        = 1'b0;
      i_succes       = 1'b0;
      i_sample_valid = 1'b0;
      // Captured values must not follow later input changes.
      i_cmd_code     = 4'($urandom);
      i_sample       = $urandom;
      chk({tag, " busy after E0"}, {31'd0, o_busy}, 32'd1);
      chk({tag, " drop before E0+1"}, {31'd0, o_drop}, 32'd0);
      @(negedge clk);
      chk({tag, " drop at E0+1"}, {31'd0, o_drop}, {31'd0, t.drop});
      got      = 1'b0;
      done_cyc = 0;
      for (int n = 0; n < 3000 && !got; n++) begin
         @(negedge clk);
         if (collide_at > 0) begin
            if (cyc == e0 + collide_at + 2)
               chk({tag, " collision drop"}, {31'd0, o_drop}, 32'd1);
            if (cyc == e0 + collide_at + 1) i_succes = 1'b0;
            if (cyc == e0 + collide_at) i_succes = 1'b1;
         end
         if (!o_done && !o_busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s busy dropped early: cycle %0d", tag, cyc - e0);
            got = 1'b1;
         end
         if (o_done) begin
            got      = 1'b1;
            done_cyc = cyc;
         end
      end
      if (!got) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s done timeout: got none, expected pulse", tag);
      end else begin
         chk({tag, " done cycle"}, done_cyc - e0, 2 + exp_q.size() * 10 * B);
         chk({tag, " busy with done"}, {31'd0, o_busy}, 32'd0);
      end
      chk({tag, " tx fall cycle"}, first_fall - e0, 32'd2);
      chk({tag, " byte count"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         chk($sformatf("%s byte%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
   endtask

   initial begin
      vec_t v;
      int   r, target, base;
      rst_n          = 1'b0;
      i_succes       = 1'b0;
      i_error        = 1'b0;
      i_sample_valid = 1'b0;
      i_cmd_code     = 4'd0;
      i_sample       = 32'd0;

      tbl[0] = '{1'b0, 1'b1, 1'b0, 4'h2, 32'h0,        K_ACK,  1'b0};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 4'h5, 32'h0,        K_NAK,  1'b1};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 4'h0, 32'hDEADBEEF, K_DATA, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 4'hF, 32'h12345678, K_ACK,  1'b1};
      tbl[4] = '{1'b1, 1'b1, 1'b1, 4'h7, 32'h0BADF00D, K_NAK,  1'b1};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 4'h0, 32'h01020304, K_DATA, 1'b0};
      for (int i = 6; i < 12; i++) begin
         r = $urandom_range(1, 7);
         tbl[i].e    = r[2];
         tbl[i].s    = r[1];
         tbl[i].v    = r[0];
         tbl[i].code = 4'($urandom);
         tbl[i].samp = $urandom;
         tbl[i].kind = r[2] ? K_NAK : (r[1] ? K_ACK : K_DATA);
         tbl[i].drop = (int'(r[2]) + int'(r[1]) + int'(r[0])) > 1;
      end

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset tx",   {31'd0, o_tx},   32'd1);
      chk("reset busy", {31'd0, o_busy}, 32'd0);
      chk("reset done", {31'd0, o_done}, 32'd0);
      chk("reset drop", {31'd0, o_drop}, 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         run_req(tbl[i], 0, $sformatf("vec%0d", i));
         if (i == 0 && rx_q.size() > 1) chk("ack code 2 head", {24'd0, rx_q[1]}, 32'hA2);
`ifdef RESPONSE_CHECKSUM_EN
         if (i == 0 && rx_q.size() > 2) chk("ack code 2 checksum", {24'd0, rx_q[2]}, 32'hA2);
         if (i == 5 && rx_q.size() > 6) chk("data checksum", {24'd0, rx_q[6]}, 32'hD0);
`endif
         repeat (3) @(negedge clk);
      end

      // Request during a DATA packet is dropped and never answered.
      v = '{1'b0, 1'b0, 1'b1, 4'h0, 32'hCAFEF00D, K_DATA, 1'b0};
      run_req(v, 50, "collide");
      repeat (400) @(negedge clk);
      chk("collide no ack busy", {31'd0, o_busy}, 32'd0);
      chk("collide no extra bytes", rx_q.size(), exp_q.size());

      // Reset in the middle of payload byte 2.
      @(negedge clk);
      i_sample_valid = 1'b1;
      i_sample       = 32'h55AA33CC;
      @(negedge clk);
      i_sample_valid = 1'b0;
      base   = cyc;
      target = base + 2 + 4 * 10 * B + 40;
      while (cyc < target) @(negedge clk);
      chk("pre-reset busy", {31'd0, o_busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid reset tx",   {31'd0, o_tx},   32'd1);
      chk("mid reset busy", {31'd0, o_busy}, 32'd0);
      chk("mid reset done", {31'd0, o_done}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      chk("post reset tx", {31'd0, o_tx}, 32'd1);
      v = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0, K_NAK, 1'b0};
      run_req(v, 0, "after reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
